// File: rtl/pad_tile_sequencer.sv
// Walks pad_unit across a tiled feature map in raster order, deriving border pads per tile.
// Optional PAD_SEQ_PERF_EN adds the perf_stall_cycles stall counter output.
module pad_tile_sequencer #(
  parameter int CNT_W   = 8,
  parameter int OUT_DIM = 10,
  parameter int TILE    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_start,
  input  logic [CNT_W-1:0]   job_tiles_h,
  input  logic [CNT_W-1:0]   job_tiles_w,
  input  logic [3:0]         cfg_pad_top,
  input  logic [3:0]         cfg_pad_bottom,
  input  logic [3:0]         cfg_pad_left,
  input  logic [3:0]         cfg_pad_right,
  input  logic [15:0]        cfg_pad_value,
  input  logic               job_abort,
  output logic               busy,
  output logic               job_done,
  output logic               job_err,
  output logic               job_aborted,
  output logic [CNT_W-1:0]   tile_row,
  output logic [CNT_W-1:0]   tile_col,
  output logic               tile_req,
  input  logic               tile_ack,
  output logic               pu_valid_in,
  input  logic               pu_ready_in,
  output logic [3:0]         pu_pad_top,
  output logic [3:0]         pu_pad_bottom,
  output logic [3:0]         pu_pad_left,
  output logic [3:0]         pu_pad_right,
  output logic [15:0]        pu_pad_value,
  input  logic               pu_valid_out,
  output logic               pu_ready_out,
  output logic               sink_valid,
  input  logic               sink_ready,
`ifdef PAD_SEQ_PERF_EN
  output logic [31:0]        perf_stall_cycles,
`endif
  output logic [2*CNT_W-1:0] tiles_done
);

  localparam int PAD_BUDGET = OUT_DIM - TILE;
  localparam int TD_W       = 2 * CNT_W;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_OUT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] job_h, job_h_nxt;
  logic [CNT_W-1:0] job_w, job_w_nxt;
  logic [3:0]       cfg_top, cfg_top_nxt;
  logic [3:0]       cfg_bottom, cfg_bottom_nxt;
  logic [3:0]       cfg_left, cfg_left_nxt;
  logic [3:0]       cfg_right, cfg_right_nxt;
  logic [15:0]      cfg_value, cfg_value_nxt;

  logic             busy_nxt, job_done_nxt, job_err_nxt, job_aborted_nxt;
  logic [CNT_W-1:0] tile_row_nxt, tile_col_nxt;
  logic             tile_req_nxt, pu_valid_in_nxt;
  logic [3:0]       pad_top_nxt, pad_bottom_nxt, pad_left_nxt, pad_right_nxt;
  logic [15:0]      pad_value_nxt;
  logic [TD_W-1:0]  tiles_done_nxt;

  logic [4:0] sum_tb, sum_lr;
  logic       cfg_bad, last_row, last_col, out_hs;

  assign sum_tb   = {1'b0, cfg_pad_top} + {1'b0, cfg_pad_bottom};
  assign sum_lr   = {1'b0, cfg_pad_left} + {1'b0, cfg_pad_right};
  assign cfg_bad  = (sum_tb > 5'(PAD_BUDGET)) || (sum_lr > 5'(PAD_BUDGET));
  assign last_row = (tile_row == job_h - CNT_W'(1));
  assign last_col = (tile_col == job_w - CNT_W'(1));
  assign out_hs   = pu_valid_out && sink_ready;

  assign pu_ready_out = (state == WAIT_OUT) && sink_ready;
  assign sink_valid   = pu_valid_out;

`ifdef PAD_SEQ_PERF_EN
  logic [31:0] perf_nxt;
  logic        stall;

  assign stall = busy && ((tile_req && !tile_ack) ||
                          (pu_valid_in && !pu_ready_in) ||
                          (pu_valid_out && !sink_ready));

  always_comb begin
    perf_nxt = perf_stall_cycles;
    if (state == IDLE && job_start) begin
      perf_nxt = '0;
    end else if (stall && perf_stall_cycles != '1) begin
      perf_nxt = perf_stall_cycles + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
    end else begin
      perf_stall_cycles <= perf_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt       = state;
    job_h_nxt       = job_h;
    job_w_nxt       = job_w;
    cfg_top_nxt     = cfg_top;
    cfg_bottom_nxt  = cfg_bottom;
    cfg_left_nxt    = cfg_left;
    cfg_right_nxt   = cfg_right;
    cfg_value_nxt   = cfg_value;
    busy_nxt        = busy;
    job_done_nxt    = 1'b0;
    job_err_nxt     = 1'b0;
    job_aborted_nxt = 1'b0;
    tile_row_nxt    = tile_row;
    tile_col_nxt    = tile_col;
    tile_req_nxt    = tile_req;
    pu_valid_in_nxt = pu_valid_in;
    pad_top_nxt     = pu_pad_top;
    pad_bottom_nxt  = pu_pad_bottom;
    pad_left_nxt    = pu_pad_left;
    pad_right_nxt   = pu_pad_right;
    pad_value_nxt   = pu_pad_value;
    tiles_done_nxt  = tiles_done;

    unique case (state)
      IDLE: begin
        if (job_start) begin
          job_h_nxt      = job_tiles_h;
          job_w_nxt      = job_tiles_w;
          cfg_top_nxt    = cfg_pad_top;
          cfg_bottom_nxt = cfg_pad_bottom;
          cfg_left_nxt   = cfg_pad_left;
          cfg_right_nxt  = cfg_pad_right;
          cfg_value_nxt  = cfg_pad_value;
          tiles_done_nxt = '0;
          if (cfg_bad) begin
            job_err_nxt = 1'b1;
          end else if (job_tiles_h == '0 || job_tiles_w == '0) begin
            state_nxt    = DONE;
            job_done_nxt = 1'b1;
          end else begin
            tile_row_nxt = '0;
            tile_col_nxt = '0;
            busy_nxt     = 1'b1;
            tile_req_nxt = 1'b1;
            state_nxt    = FETCH;
          end
        end
      end

      FETCH: begin
        // Pads are refreshed every FETCH cycle and frozen once the tile is issued.
        pad_top_nxt    = (tile_row == '0) ? cfg_top : '0;
        pad_bottom_nxt = last_row ? cfg_bottom : '0;
        pad_left_nxt   = (tile_col == '0) ? cfg_left : '0;
        pad_right_nxt  = last_col ? cfg_right : '0;
        pad_value_nxt  = cfg_value;
        if (tile_ack) begin
          pu_valid_in_nxt = 1'b1;
          state_nxt       = ISSUE;
        end
      end

      ISSUE: begin
        if (pu_valid_in && pu_ready_in) begin
          tile_req_nxt    = 1'b0;
          pu_valid_in_nxt = 1'b0;
          state_nxt       = WAIT_OUT;
        end
      end

      WAIT_OUT: begin
        if (out_hs) begin
          tiles_done_nxt = tiles_done + TD_W'(1);
          if (last_row && last_col) begin
            busy_nxt     = 1'b0;
            job_done_nxt = 1'b1;
            state_nxt    = DONE;
          end else begin
            if (last_col) begin
              tile_col_nxt = '0;
              tile_row_nxt = tile_row + CNT_W'(1);
            end else begin
              tile_col_nxt = tile_col + CNT_W'(1);
            end
            tile_req_nxt = 1'b1;
            state_nxt    = FETCH;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort overrides whatever the state logic decided, including a completing handshake.
    if (job_abort && state != IDLE) begin
      state_nxt       = IDLE;
      busy_nxt        = 1'b0;
      tile_req_nxt    = 1'b0;
      pu_valid_in_nxt = 1'b0;
      job_done_nxt    = 1'b0;
      job_aborted_nxt = 1'b1;
      tiles_done_nxt  = tiles_done;
      tile_row_nxt    = tile_row;
      tile_col_nxt    = tile_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      job_h         <= '0;
      job_w         <= '0;
      cfg_top       <= '0;
      cfg_bottom    <= '0;
      cfg_left      <= '0;
      cfg_right     <= '0;
      cfg_value     <= '0;
      busy          <= 1'b0;
      job_done      <= 1'b0;
      job_err       <= 1'b0;
      job_aborted   <= 1'b0;
      tile_row      <= '0;
      tile_col      <= '0;
      tile_req      <= 1'b0;
      pu_valid_in   <= 1'b0;
      pu_pad_top    <= '0;
      pu_pad_bottom <= '0;
      pu_pad_left   <= '0;
      pu_pad_right  <= '0;
      pu_pad_value  <= '0;
      tiles_done    <= '0;
    end else begin
      state         <= state_nxt;
      job_h         <= job_h_nxt;
      job_w         <= job_w_nxt;
      cfg_top       <= cfg_top_nxt;
      cfg_bottom    <= cfg_bottom_nxt;
      cfg_left      <= cfg_left_nxt;
      cfg_right     <= cfg_right_nxt;
      cfg_value     <= cfg_value_nxt;
      busy          <= busy_nxt;
      job_done      <= job_done_nxt;
      job_err       <= job_err_nxt;
      job_aborted   <= job_aborted_nxt;
      tile_row      <= tile_row_nxt;
      tile_col      <= tile_col_nxt;
      tile_req      <= tile_req_nxt;
      pu_valid_in   <= pu_valid_in_nxt;
      pu_pad_top    <= pad_top_nxt;
      pu_pad_bottom <= pad_bottom_nxt;
      pu_pad_left   <= pad_left_nxt;
      pu_pad_right  <= pad_right_nxt;
      pu_pad_value  <= pad_value_nxt;
      tiles_done    <= tiles_done_nxt;
    end
  end

endmodule

// File: tb/tb_pad_tile_sequencer.sv
// Randomised bench for pad_tile_sequencer: models fetcher, pad_unit and sink, and
// checks tile order, per-tile pads and job outcomes against plain arithmetic.
module tb_pad_tile_sequencer;
  localparam int CNT_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               job_start = 1'b0;
  logic [CNT_W-1:0]   job_tiles_h = '0;
  logic [CNT_W-1:0]   job_tiles_w = '0;
  logic [3:0]         cfg_pad_top = '0, cfg_pad_bottom = '0, cfg_pad_left = '0, cfg_pad_right = '0;
  logic [15:0]        cfg_pad_value = '0;
  logic               job_abort = 1'b0;
  logic               busy, job_done, job_err, job_aborted;
  logic [CNT_W-1:0]   tile_row, tile_col;
  logic               tile_req;
  logic               tile_ack = 1'b0;
  logic               pu_valid_in;
  logic               pu_ready_in = 1'b0;
  logic [3:0]         pu_pad_top, pu_pad_bottom, pu_pad_left, pu_pad_right;
  logic [15:0]        pu_pad_value;
  logic               pu_valid_out = 1'b0;
  logic               pu_ready_out;
  logic               sink_valid;
  logic               sink_ready = 1'b0;
  logic [2*CNT_W-1:0] tiles_done;
`ifdef PAD_SEQ_PERF_EN
  logic [31:0]        perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  pad_tile_sequencer #(.CNT_W(CNT_W), .OUT_DIM(10), .TILE(8)) dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start),
    .job_tiles_h(job_tiles_h), .job_tiles_w(job_tiles_w),
    .cfg_pad_top(cfg_pad_top), .cfg_pad_bottom(cfg_pad_bottom),
    .cfg_pad_left(cfg_pad_left), .cfg_pad_right(cfg_pad_right),
    .cfg_pad_value(cfg_pad_value), .job_abort(job_abort),
    .busy(busy), .job_done(job_done), .job_err(job_err), .job_aborted(job_aborted),
    .tile_row(tile_row), .tile_col(tile_col), .tile_req(tile_req), .tile_ack(tile_ack),
    .pu_valid_in(pu_valid_in), .pu_ready_in(pu_ready_in),
    .pu_pad_top(pu_pad_top), .pu_pad_bottom(pu_pad_bottom),
    .pu_pad_left(pu_pad_left), .pu_pad_right(pu_pad_right),
    .pu_pad_value(pu_pad_value), .pu_valid_out(pu_valid_out), .pu_ready_out(pu_ready_out),
    .sink_valid(sink_valid), .sink_ready(sink_ready),
`ifdef PAD_SEQ_PERF_EN
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .tiles_done(tiles_done)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: everything ready; mode 1: random handshakes; mode 2: fixed backpressure on tile 0.
  task automatic run_job(input int h, input int w, input int pt, input int pb, input int pl,
                         input int pr, input logic [15:0] pv, input int mode,
                         input int abort_at, input int rst_at);
    int total, accepted, completed, lat, ri_low, sr_low, er, ec, cyc;
    bit err, in_wait, hs_last, expect_done, abort_now, finished;
    logic [15:0] acc_pads, exp_pads;
    logic [3:0] et, eb, el, erp;
    err = (pt + pb > 2) || (pl + pr > 2);
    total = err ? 0 : h * w;
    accepted = 0; completed = 0; lat = 0; ri_low = 0; sr_low = 0; cyc = 0;
    in_wait = 0; hs_last = 0; expect_done = 0; abort_now = 0; finished = 0;
    acc_pads = '0;

    @(negedge clk);
    job_tiles_h = h[CNT_W-1:0];
    job_tiles_w = w[CNT_W-1:0];
    cfg_pad_top = pt[3:0]; cfg_pad_bottom = pb[3:0];
    cfg_pad_left = pl[3:0]; cfg_pad_right = pr[3:0];
    cfg_pad_value = pv;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;

    if (err) begin
      check("err_pulse", job_err, 1);
      check("err_busy", busy, 0);
      check("err_tiles_done", tiles_done, 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("err_quiet", {busy, tile_req, job_err}, 0);
      end
      return;
    end
    if (total == 0) begin
      check("zero_done", job_done, 1);
      check("zero_tiles_done", tiles_done, 0);
      check("zero_busy", busy, 0);
      @(negedge clk);
      check("zero_one_shot", {job_done, pu_valid_in, busy, tile_req}, 0);
      return;
    end
    check("start_busy", busy, 1);

    while (!finished && cyc < 4000) begin
      cyc++;
      if (hs_last) begin
        pu_valid_out = 1'b0;
        hs_last = 0;
      end
      if (abort_now) begin
        job_abort = 1'b0;
        sink_ready = 1'b1;
        check("abort_pulse", job_aborted, 1);
        check("abort_idle", {busy, tile_req, pu_valid_in, job_done}, 0);
        check("abort_tiles_done", tiles_done, completed);
        #1 check("abort_ready_out", pu_ready_out, 0);
        finished = 1;
      end else if (expect_done || job_done) begin
        check("done_pulse", job_done, expect_done);
        check("done_tiles_done", tiles_done, total);
        check("done_busy", busy, 0);
        @(negedge clk);
        check("done_one_shot", job_done, 0);
        finished = 1;
      end else begin
        if (in_wait && !pu_valid_out) begin
          if (lat == 0) pu_valid_out = 1'b1;
          else lat--;
        end
        if (rst_at >= 0 && in_wait && completed == rst_at) begin
          pu_valid_out = 1'b0;
          sink_ready = 1'b1;
          #2 rst_n = 1'b0;
          #1;
          check("rst_ctrl", {busy, tile_req, pu_valid_in, pu_ready_out, job_done, job_err, job_aborted}, 0);
          check("rst_index", {tile_row, tile_col}, 0);
          check("rst_tiles_done", tiles_done, 0);
          check("rst_pads", {pu_pad_top, pu_pad_bottom, pu_pad_left, pu_pad_right}, 0);
          check("rst_value", pu_pad_value, 0);
          @(negedge clk);
          rst_n = 1'b1;
          finished = 1;
        end else begin
          case (mode)
            0: begin
              sink_ready = 1'b1; tile_ack = 1'b1; pu_ready_in = 1'b1;
            end
            1: begin
              sink_ready  = ($urandom_range(0, 2) != 0);
              tile_ack    = tile_req && ($urandom_range(0, 2) != 0);
              pu_ready_in = ($urandom_range(0, 2) != 0);
            end
            default: begin
              tile_ack = 1'b1;
              if (pu_valid_in && ri_low < 3) begin pu_ready_in = 1'b0; ri_low++; end
              else pu_ready_in = 1'b1;
              if (pu_valid_out && sr_low < 4) begin sink_ready = 1'b0; sr_low++; end
              else sink_ready = 1'b1;
            end
          endcase
          #1 check("ready_out", pu_ready_out, in_wait ? sink_ready : 1'b0);
          if (abort_at >= 0 && completed == abort_at && tile_req) begin
            job_abort = 1'b1;
            abort_now = 1;
          end else if (pu_valid_in && pu_ready_in) begin
            er = accepted / w;
            ec = accepted % w;
            et  = (er == 0)     ? pt[3:0] : 4'd0;
            eb  = (er == h - 1) ? pb[3:0] : 4'd0;
            el  = (ec == 0)     ? pl[3:0] : 4'd0;
            erp = (ec == w - 1) ? pr[3:0] : 4'd0;
            exp_pads = {et, eb, el, erp};
            check("acc_row", tile_row, er);
            check("acc_col", tile_col, ec);
            check("acc_req", tile_req, 1);
            check("acc_pads", {pu_pad_top, pu_pad_bottom, pu_pad_left, pu_pad_right}, exp_pads);
            check("acc_value", pu_pad_value, pv);
            acc_pads = exp_pads;
            accepted++;
            in_wait = 1;
            lat = (mode == 1) ? $urandom_range(0, 2) : 0;
          end else if (pu_valid_out && sink_ready) begin
            check("hs_pads", {pu_pad_top, pu_pad_bottom, pu_pad_left, pu_pad_right}, acc_pads);
            check("hs_no_valid_in", pu_valid_in, 0);
            completed++;
            in_wait = 0;
            hs_last = 1;
            if (completed == total) expect_done = 1;
          end
        end
      end
      if (!finished) @(negedge clk);
    end
    check("job_timeout", finished, 1);
    pu_valid_out = 1'b0;
    job_abort = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, w, pt, pb, pl, pr, ab;
    #12;
    check("reset_ctrl", {busy, job_done, job_err, job_aborted, tile_req, pu_valid_in, pu_ready_out}, 0);
    check("reset_index", {tile_row, tile_col}, 0);
    check("reset_pads", {pu_pad_top, pu_pad_bottom, pu_pad_left, pu_pad_right}, 0);
    check("reset_value_td", {pu_pad_value, tiles_done}, 0);
`ifdef PAD_SEQ_PERF_EN
    check("reset_perf", perf_stall_cycles, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_job(2, 3, 1, 1, 1, 1, 16'hA5A5, 0, -1, -1);
    run_job(1, 1, 2, 0, 0, 2, 16'h1234, 0, -1, -1);
    run_job(2, 2, 2, 1, 0, 0, 16'h0000, 0, -1, -1);
    run_job(3, 0, 1, 1, 1, 1, 16'h0007, 0, -1, -1);
    run_job(1, 2, 1, 0, 1, 1, 16'hBEEF, 2, -1, -1);
`ifdef PAD_SEQ_PERF_EN
    check("perf_stall", perf_stall_cycles, 7);
`endif
    run_job(2, 2, 0, 1, 1, 0, 16'h0055, 0, 2, -1);
    run_job(3, 2, 1, 1, 0, 2, 16'h0099, 1, -1, -1);

    for (int j = 0; j < 24; j++) begin
      h = $urandom_range(1, 4);
      w = $urandom_range(1, 4);
      if ($urandom_range(0, 9) == 0) w = 0;
      pt = $urandom_range(0, 2); pb = $urandom_range(0, 2 - pt);
      pl = $urandom_range(0, 2); pr = $urandom_range(0, 2 - pl);
      if ($urandom_range(0, 5) == 0) pb = $urandom_range(0, 3);
      ab = -1;
      if (h * w > 0 && $urandom_range(0, 4) == 0) ab = $urandom_range(0, h * w - 1);
      run_job(h, w, pt, pb, pl, pr, 16'($urandom), 1, ab, -1);
    end

    run_job(1, 3, 1, 1, 1, 1, 16'h0042, 0, -1, 1);
    run_job(2, 2, 1, 1, 1, 1, 16'h0077, 1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
